z88_mem_arb: RTL and testbench

Z88 main-memory bus arbiter and strobe sequencer. Shares the single 22-bit memory address bus, `cdi` read bus and chip enables between the Z80 CPU port and the LCD screen fetch engine. The CPU has priority; a starvation counter guarantees screen fetch slots. Sits between the Blink CPU interface, the screen engine and the external ROM/RAM/card-slot pins. It is the sole driver of `ma`, `roe_n`, `rwe_n` and all chip enables.

---
 rtl/z88_mem_arb_if.sv | 38 +++
 rtl/z88_mem_arb.sv | 160 ++++++++++++++++
 tb/tb_z88_mem_arb.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/z88_mem_arb_if.sv
// Bus bundle between the Z88 memory arbiter, its two requesters and the memory pins.
// slave: the arbiter side; master: CPU port, screen engine and memory environment.
interface z88_mem_arb_if;
  logic        lcdon;
  logic        cpu_req;
  logic        cpu_wr;
  logic [21:0] cpu_a;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_ack;
  logic        cpu_wait_n;
  logic        scr_req;
  logic [21:0] scr_a;
  logic [7:0]  scr_di;
  logic        scr_ack;
  logic [21:0] ma;
  logic [7:0]  cdi;
  logic [7:0]  cdo;
  logic        roe_n;
  logic        rwe_n;
  logic        ipce_n;
  logic        irce_n;
  logic        se1_n;
  logic        se2_n;
  logic        se3_n;

  modport slave (
    input  lcdon, cpu_req, cpu_wr, cpu_a, cpu_do, scr_req, scr_a, cdi,
    output cpu_di, cpu_ack, cpu_wait_n, scr_di, scr_ack, ma, cdo,
           roe_n, rwe_n, ipce_n, irce_n, se1_n, se2_n, se3_n
  );

  modport master (
    output lcdon, cpu_req, cpu_wr, cpu_a, cpu_do, scr_req, scr_a, cdi,
    input  cpu_di, cpu_ack, cpu_wait_n, scr_di, scr_ack, ma, cdo,
           roe_n, rwe_n, ipce_n, irce_n, se1_n, se2_n, se3_n
  );
endinterface

// File: rtl/z88_mem_arb.sv
// Z88 main-memory arbiter: CPU-priority sharing of the memory bus with the screen
// fetch engine, starvation-forced screen slots, registered strobes and chip enables.
module z88_mem_arb #(
  parameter int unsigned ACC_CYC = 2,
  parameter int unsigned STARVE  = 4
) (
  input  logic         mck,
  input  logic         rin_n,
  z88_mem_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, REL} state_e;
  typedef enum logic       {OWN_CPU, OWN_SCR} owner_e;

  state_e      state_q,   state_d;
  owner_e      owner_q,   owner_d;
  logic [2:0]  acnt_q,    acnt_d;
  logic [3:0]  starve_q,  starve_d;
  logic        wr_q,      wr_d;
  logic [21:0] ma_q,      ma_d;
  logic [7:0]  cdo_q,     cdo_d;
  logic [7:0]  cpu_di_q,  cpu_di_d;
  logic [7:0]  scr_di_q,  scr_di_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        scr_ack_q, scr_ack_d;
  logic        roe_n_q,   roe_n_d;
  logic        rwe_n_q,   rwe_n_d;
  // {ipce_n, irce_n, se1_n, se2_n, se3_n}
  logic [4:0]  ce_n_q,    ce_n_d;

  logic sreq;
  logic grant_cpu;
  logic grant_scr;
  logic acc_done;
  logic acc_next;
  logic rom_next;

  // State register
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_CPU;
      acnt_q    <= '0;
      starve_q  <= '0;
      wr_q      <= 1'b0;
      ma_q      <= '0;
      cdo_q     <= '0;
      cpu_di_q  <= '0;
      scr_di_q  <= '0;
      cpu_ack_q <= 1'b0;
      scr_ack_q <= 1'b0;
      roe_n_q   <= 1'b1;
      rwe_n_q   <= 1'b1;
      ce_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      acnt_q    <= acnt_d;
      starve_q  <= starve_d;
      wr_q      <= wr_d;
      ma_q      <= ma_d;
      cdo_q     <= cdo_d;
      cpu_di_q  <= cpu_di_d;
      scr_di_q  <= scr_di_d;
      cpu_ack_q <= cpu_ack_d;
      scr_ack_q <= scr_ack_d;
      roe_n_q   <= roe_n_d;
      rwe_n_q   <= rwe_n_d;
      ce_n_q    <= ce_n_d;
    end
  end

  // Next-state: arbitration in IDLE, access countdown in ACC, starvation tracking
  always_comb begin
    sreq      = bus.scr_req & bus.lcdon;
    grant_scr = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == IDLE) begin
      grant_scr = sreq & (~bus.cpu_req | (starve_q == 4'(STARVE)));
      grant_cpu = bus.cpu_req & ~grant_scr;
    end
    acc_done = (state_q == ACC) && (acnt_q == '0);

    state_d  = state_q;
    owner_d  = owner_q;
    acnt_d   = acnt_q;
    wr_d     = wr_q;
    ma_d     = ma_q;
    cdo_d    = cdo_q;
    starve_d = starve_q;

    unique case (state_q)
      IDLE: begin
        if (grant_cpu | grant_scr) begin
          state_d = ACC;
          owner_d = grant_scr ? OWN_SCR : OWN_CPU;
          acnt_d  = 3'(ACC_CYC - 1);
          wr_d    = grant_cpu & bus.cpu_wr;
          ma_d    = grant_scr ? bus.scr_a : bus.cpu_a;
          cdo_d   = bus.cpu_do;
        end
      end
      ACC: begin
        if (acc_done) state_d = REL;
        else          acnt_d  = acnt_q - 3'd1;
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_scr)
      starve_d = '0;
    else if (grant_cpu && sreq && (starve_q < 4'(STARVE)))
      starve_d = starve_q + 4'd1;
  end

  // Outputs: strobes are computed from the next state/address so the registered
  // pins are low for exactly the ACC cycles.
  always_comb begin
    cpu_ack_d = acc_done & (owner_q == OWN_CPU);
    scr_ack_d = acc_done & (owner_q == OWN_SCR);
    cpu_di_d  = cpu_ack_d ? bus.cdi : cpu_di_q;
    scr_di_d  = scr_ack_d ? bus.cdi : scr_di_q;

    acc_next = (state_d == ACC);
    rom_next = (ma_d[21:19] == 3'b000);

    ce_n_d = '1;
    if (acc_next) begin
      if (rom_next)                    ce_n_d[4] = 1'b0;
      else if (ma_d[21:19] == 3'b001)  ce_n_d[3] = 1'b0;
      else begin
        unique case (ma_d[21:20])
          2'b01:   ce_n_d[2] = 1'b0;
          2'b10:   ce_n_d[1] = 1'b0;
          default: ce_n_d[0] = 1'b0;
        endcase
      end
    end

    roe_n_d = ~(acc_next & ~wr_d);
    rwe_n_d = ~(acc_next & wr_d & ~rom_next);
  end

  assign bus.ma      = ma_q;
  assign bus.cdo     = cdo_q;
  assign bus.cpu_di  = cpu_di_q;
  assign bus.scr_di  = scr_di_q;
  assign bus.cpu_ack = cpu_ack_q;
  assign bus.scr_ack = scr_ack_q;
  assign bus.roe_n   = roe_n_q;
  assign bus.rwe_n   = rwe_n_q;
  assign bus.ipce_n  = ce_n_q[4];
  assign bus.irce_n  = ce_n_q[3];
  assign bus.se1_n   = ce_n_q[2];
  assign bus.se2_n   = ce_n_q[1];
  assign bus.se3_n   = ce_n_q[0];

  assign bus.cpu_wait_n = ~(bus.cpu_req &
                            ~(((state_q == ACC) || (state_q == REL)) && (owner_q == OWN_CPU)));
endmodule

// File: tb/tb_z88_mem_arb.sv
// Randomized scoreboard bench for z88_mem_arb: requester drivers push transactions,
// a timing/arbitration model in the monitor predicts grants, strobes and acks.
module tb_z88_mem_arb;
  localparam int unsigned N  = 2;
  localparam int unsigned SV = 4;

  typedef struct {
    logic [21:0] a;
    logic        w;
    logic [7:0]  d;
  } txn_t;

  logic mck = 1'b0;
  logic rin_n;
  z88_mem_arb_if bus ();

  z88_mem_arb #(.ACC_CYC(N), .STARVE(SV)) dut (
    .mck   (mck),
    .rin_n (rin_n),
    .bus   (bus)
  );

  always #5 mck = ~mck;

  function automatic logic [7:0] mem_f(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  function automatic logic [4:0] ce_of(input logic [21:0] a);
    if (a[21:19] == 3'b000) return 5'b01111;
    if (a[21:19] == 3'b001) return 5'b10111;
    case (a[21:20])
      2'b01:   return 5'b11011;
      2'b10:   return 5'b11101;
      default: return 5'b11110;
    endcase
  endfunction

  assign bus.cdi = mem_f(bus.ma);

  int   vectors = 0;
  int   miscompares = 0;
  txn_t cpu_q[$];
  txn_t scr_q[$];
  bit   run = 0, stop = 0, hold = 0, mon_en = 0;
  bit   cpu_done = 0, scr_done = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [6:0] pins();
    return {bus.ipce_n, bus.irce_n, bus.se1_n, bus.se2_n, bus.se3_n, bus.roe_n, bus.rwe_n};
  endfunction

  // CPU requester
  initial begin
    wait (run);
    while (!stop) begin
      txn_t t;
      int unsigned n, gap;
      t.a = 22'($urandom);
      t.w = 1'($urandom_range(0, 1));
      t.d = 8'($urandom);
      cpu_q.push_back(t);
      bus.cpu_a = t.a; bus.cpu_wr = t.w; bus.cpu_do = t.d; bus.cpu_req = 1'b1;
      n = 0;
      forever begin
        @(negedge mck);
        if (bus.cpu_ack) break;
        n++;
        if (n > 2000) begin
          vectors++; miscompares++;
          $display("FAIL cpu_ack_timeout: got no ack expected ack within 2000 cycles");
          break;
        end
      end
      @(posedge mck); #1;
      bus.cpu_req = 1'b0;
      gap = hold ? 0 : $urandom_range(0, 4);
      if (gap > 0) begin
        repeat (gap) @(posedge mck);
        #1;
      end
    end
    cpu_done = 1;
  end

  // Screen requester
  initial begin
    wait (run);
    while (!stop) begin
      txn_t t;
      int unsigned n, gap;
      t.a = 22'($urandom);
      t.w = 1'b0;
      t.d = '0;
      scr_q.push_back(t);
      bus.scr_a = t.a; bus.scr_req = 1'b1;
      n = 0;
      forever begin
        @(negedge mck);
        if (bus.scr_ack) break;
        n++;
        if (n > 2000) begin
          vectors++; miscompares++;
          $display("FAIL scr_ack_timeout: got no ack expected ack within 2000 cycles");
          break;
        end
      end
      @(posedge mck); #1;
      bus.scr_req = 1'b0;
      gap = hold ? 0 : $urandom_range(0, 6);
      if (gap > 0) begin
        repeat (gap) @(posedge mck);
        #1;
      end
    end
    scr_done = 1;
  end

  // Screen enable toggling
  initial begin
    wait (run);
    while (!stop) begin
      repeat ($urandom_range(5, 60)) @(posedge mck);
      #1;
      bus.lcdon = (hold || stop) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
    end
    bus.lcdon = 1'b1;
  end

  // Monitor with behavioural arbitration/timing model
  initial begin
    int   cyc, free_at, g, starve_m;
    bit   act, own_scr, cs, ss, in_acc, ack_cyc, in_win, idle_m;
    logic [21:0] exp_ma;
    logic [7:0]  exp_cdo, cdo_prev;
    logic [4:0]  ece;
    txn_t cur;
    cyc = 0; free_at = 0; g = 0; starve_m = 0;
    act = 0; own_scr = 0; cs = 0; ss = 0;
    exp_ma = '0; exp_cdo = '0; cdo_prev = bus.cpu_do;
    cur.a = '0; cur.w = 0; cur.d = '0;
    wait (mon_en);
    forever begin
      @(negedge mck);
      cyc++;
      idle_m = (cyc >= free_at);
      if (idle_m) begin
        chk("grant", {31'd0, ~&pins()}, {31'd0, cs | ss});
        if (cs || ss) begin
          own_scr = (cs && ss) ? (starve_m == SV) : ss;
          if (own_scr) starve_m = 0;
          else if (ss && starve_m < SV) starve_m++;
          if (own_scr ? (scr_q.size() == 0) : (cpu_q.size() == 0)) begin
            vectors++; miscompares++;
            $display("FAIL queue_empty: got empty %s queue expected a pending entry", own_scr ? "scr" : "cpu");
          end else begin
            cur = own_scr ? scr_q[0] : cpu_q[0];
          end
          act = 1; g = cyc; free_at = cyc + N + 2;
          exp_ma = cur.a; exp_cdo = cdo_prev;
        end
      end
      in_acc  = act && cyc >= g && cyc < g + N;
      in_win  = act && cyc >= g && cyc <= g + N;
      ack_cyc = act && cyc == g + N;
      ece = in_acc ? ce_of(cur.a) : 5'b11111;
      chk("strobes", {25'd0, pins()},
          {25'd0, ece, ~(in_acc & ~cur.w), ~(in_acc & cur.w & (cur.a[21:19] != 3'b000))});
      chk("ma", {10'd0, bus.ma}, {10'd0, exp_ma});
      chk("cdo", {24'd0, bus.cdo}, {24'd0, exp_cdo});
      chk("acks", {30'd0, bus.cpu_ack, bus.scr_ack}, {30'd0, ack_cyc & ~own_scr, ack_cyc & own_scr});
      chk("wait_n", {31'd0, bus.cpu_wait_n}, {31'd0, ~(bus.cpu_req & ~(in_win & ~own_scr))});
      if (ack_cyc) begin
        if (own_scr) begin
          chk("scr_di", {24'd0, bus.scr_di}, {24'd0, mem_f(cur.a)});
          if (scr_q.size() != 0) void'(scr_q.pop_front());
        end else begin
          if (!cur.w) chk("cpu_di", {24'd0, bus.cpu_di}, {24'd0, mem_f(cur.a)});
          if (cpu_q.size() != 0) void'(cpu_q.pop_front());
        end
      end
      cs = bus.cpu_req;
      ss = bus.scr_req & bus.lcdon;
      cdo_prev = bus.cpu_do;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.lcdon = 1'b1; bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_a = '0;
    bus.cpu_do = '0; bus.scr_req = 1'b0; bus.scr_a = '0;
    rin_n = 1'b0;
    repeat (3) @(posedge mck);
    #1;
    chk("rst_strobes", {25'd0, pins()}, {25'd0, 7'h7F});
    chk("rst_acks", {30'd0, bus.cpu_ack, bus.scr_ack}, 32'd0);
    chk("rst_addr", {2'd0, bus.ma, bus.cdo}, 32'd0);
    chk("rst_di", {16'd0, bus.cpu_di, bus.scr_di}, 32'd0);
    chk("rst_wait_n", {31'd0, bus.cpu_wait_n}, 32'd1);
    rin_n = 1'b1;

    // Reset pulled during the ACC phase of a CPU RAM read
    @(posedge mck); #1;
    bus.cpu_a = 22'h080123; bus.cpu_wr = 1'b0; bus.cpu_req = 1'b1;
    @(posedge mck); #1;
    chk("mid_acc_strobes", {25'd0, pins()}, {25'd0, 7'b1011101});
    chk("mid_acc_ma", {10'd0, bus.ma}, {10'd0, 22'h080123});
    rin_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {25'd0, pins()}, {25'd0, 7'h7F});
    chk("mid_rst_ack", {31'd0, bus.cpu_ack}, 32'd0);
    bus.cpu_req = 1'b0;
    @(posedge mck); #1;
    chk("mid_rst_hold_ack", {31'd0, bus.cpu_ack}, 32'd0);
    rin_n = 1'b1;
    repeat (2) @(posedge mck);
    #1;
    chk("post_rst_idle", {25'd0, pins()}, {25'd0, 7'h7F});

    mon_en = 1;
    run = 1;
    repeat (3000) @(posedge mck);
    #1;
    hold = 1;
    bus.lcdon = 1'b1;
    repeat (400) @(posedge mck);
    stop = 1;
    for (int i = 0; i < 5000 && !(cpu_done && scr_done); i++) @(posedge mck);
    chk("drain", {30'd0, cpu_done, scr_done}, 32'd3);
    repeat (10) @(posedge mck);
    chk("queues_empty", cpu_q.size() + scr_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
